// File: rtl/fetch_cycle_pkg.sv
// Shared types and constants for the IF stage: state encoding, IF/ID payload, bubble encoding.
package fetch_cycle_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_BYTES       = 32'd4;

    // RUN: idle or issuing, WAIT: request outstanding, KILL: outstanding request to discard
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    function automatic if_id_t if_id_bubble(input logic [XLEN-1:0] nop);
        if_id_t b;
        b.instr    = nop;
        b.pc       = '0;
        b.pc_plus4 = '0;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_cycle_if.sv
// Instruction-memory request/ready port between the fetch stage and imem.
interface fetch_cycle_if;
    import fetch_cycle_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/fetch_cycle_if_id_reg.sv
// IF/ID pipeline register: bubble on reset/flush, hold on stall, load on accepted fetch.
module fetch_cycle_if_id_reg
    import fetch_cycle_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    output if_id_t          q
);

    if_id_t load_val;

    always_comb begin
        load_val          = if_id_bubble(NOP_INSTR);
        load_val.instr    = instr;
        load_val.pc       = pc;
        load_val.pc_plus4 = XLEN'(pc + INSTR_BYTES);
        load_val.valid    = 1'b1;
    end

    // Flush beats stall; an idle cycle with nothing accepted becomes a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= if_id_bubble(NOP_INSTR);
        end else if (flush) begin
            q <= if_id_bubble(NOP_INSTR);
        end else if (stall) begin
            q <= q;
        end else if (load) begin
            q <= load_val;
        end else begin
            q <= if_id_bubble(NOP_INSTR);
        end
    end

endmodule

// File: rtl/fetch_cycle.sv
// IF stage of the RV32I pipeline: owns PCF, runs the imem request FSM and feeds IF/ID.
module fetch_cycle
    import fetch_cycle_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             PCSrcE,
    input  logic [XLEN-1:0]  PCTargetE,
    fetch_cycle_if.master    imem,
    output logic [XLEN-1:0]  InstrD,
    output logic [XLEN-1:0]  PCD,
    output logic [XLEN-1:0]  PCPlus4D,
    output logic             ValidD,
    output logic             FetchWaitF
);

    fetch_state_e    state, state_n;
    logic [XLEN-1:0] pcf, pcf_n;
    logic [XLEN-1:0] pend, pend_n;
    logic            req;
    logic            outstanding;
    logic            accept;
    if_id_t          if_id_q;

    // A new request is only offered in RUN; WAIT/KILL keep the in-flight one asserted
    assign req         = ~rst & ((state == ST_RUN) ? ~StallF : 1'b1);
    assign outstanding = req & ~imem.imem_ready;
    assign accept      = req & imem.imem_ready & (state != ST_KILL) & ~StallF & ~PCSrcE;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pcf;
    assign FetchWaitF     = outstanding | (state != ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            pcf   <= RESET_PC;
            pend  <= '0;
        end else begin
            state <= state_n;
            pcf   <= pcf_n;
            pend  <= pend_n;
        end
    end

    // PCF stays on the outstanding address until imem completes, even across a redirect
    always_comb begin
        state_n = state;
        pcf_n   = pcf;
        pend_n  = pend;
        if (PCSrcE && ((state == ST_KILL) || outstanding)) begin
            if (!imem.imem_ready) begin
                pend_n  = PCTargetE;
                state_n = ST_KILL;
            end else begin
                pcf_n   = PCTargetE;
                state_n = ST_RUN;
            end
        end else if (PCSrcE) begin
            pcf_n   = PCTargetE;
            state_n = ST_RUN;
        end else if ((state == ST_KILL) && imem.imem_ready) begin
            pcf_n   = pend;
            state_n = ST_RUN;
        end else if (accept) begin
            pcf_n   = XLEN'(pcf + INSTR_BYTES);
            state_n = ST_RUN;
        end else if (outstanding && (state != ST_KILL)) begin
            state_n = ST_WAIT;
        end else if ((state == ST_WAIT) && imem.imem_ready && StallF) begin
            state_n = ST_RUN;
        end
    end

    // A redirect always squashes IF/ID regardless of the hazard unit
    fetch_cycle_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .flush (FlushD | PCSrcE),
        .stall (StallD),
        .load  (accept),
        .instr (imem.imem_rdata),
        .pc    (pcf),
        .q     (if_id_q)
    );

    assign InstrD   = if_id_q.instr;
    assign PCD      = if_id_q.pc;
    assign PCPlus4D = if_id_q.pc_plus4;
    assign ValidD   = if_id_q.valid;

endmodule
